// File: rtl/icache_bank_req_scheduler.sv
// Shares one instruction-cache bank request port between core fetch (CH0) and
// other L2 fetchers (CH1) using weighted round-robin, stall hold and credit limiting.
module icache_bank_req_scheduler #(
  parameter int ADDR_MEM_WIDTH  = 32,
  parameter int ID_WIDTH        = 6,
  parameter int WEIGHT_WIDTH    = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      data_req_CH0_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_CH0_i,
  input  logic [ID_WIDTH-1:0]       data_ID_CH0_i,
  output logic                      data_gnt_CH0_o,

  input  logic                      data_req_CH1_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_CH1_i,
  input  logic [ID_WIDTH-1:0]       data_ID_CH1_i,
  output logic                      data_gnt_CH1_o,

  output logic                      data_req_o,
  output logic [ADDR_MEM_WIDTH-1:0] data_add_o,
  output logic [ID_WIDTH-1:0]       data_ID_o,
  input  logic                      data_gnt_i,
  input  logic                      data_r_valid_i,

  input  logic [WEIGHT_WIDTH-1:0]   cfg_weight_ch0_i,
  output logic [CNT_WIDTH-1:0]      outstanding_o,
  output logic                      err_underflow_o
);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_e;

  state_e                  state_q;
  logic [WEIGHT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [WEIGHT_WIDTH-1:0] weight_q;
  logic [CNT_WIDTH-1:0]    outst_q, outst_d;
  logic                    err_q, err_d;

  logic sel;
  logic req_sel;
  logic credit_ok;
  logic req_out;
  logic xfer;

  // Channel selection: HOLD states pin the channel until the bank accepts it.
  always_comb begin
    sel = 1'b0;
    case (state_q)
      HOLD0: sel = 1'b0;
      HOLD1: sel = 1'b1;
      default: begin
        if (data_req_CH1_i && !data_req_CH0_i)
          sel = 1'b1;
        else if (data_req_CH1_i && data_req_CH0_i)
          sel = !(wcnt_q < weight_q);
        else
          sel = 1'b0;
      end
    endcase
  end

  assign req_sel   = sel ? data_req_CH1_i : data_req_CH0_i;
  assign credit_ok = (outst_q < CNT_WIDTH'(MAX_OUTSTANDING));
  assign req_out   = !rst && credit_ok && req_sel;
  assign xfer      = req_out && data_gnt_i;

  assign data_req_o     = req_out;
  assign data_gnt_CH0_o = xfer && !sel;
  assign data_gnt_CH1_o = xfer && sel;

  always_comb begin
    data_add_o = data_add_CH0_i;
    data_ID_o  = data_ID_CH0_i;
    if (rst) begin
      data_add_o = '0;
      data_ID_o  = '0;
    end else if (req_out && sel) begin
      data_add_o = data_add_CH1_i;
      data_ID_o  = data_ID_CH1_i;
    end
  end

  // CH0 wins only count against the weight when CH1 was actually waiting.
  always_comb begin
    wcnt_d = wcnt_q;
    if (xfer && sel)
      wcnt_d = '0;
    else if (xfer && !sel && data_req_CH1_i && !(&wcnt_q))
      wcnt_d = wcnt_q + 1'b1;
  end

  // A response with nothing in flight is flagged, never wrapped.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (xfer && !data_r_valid_i)
      outst_d = outst_q + 1'b1;
    else if (!xfer && data_r_valid_i) begin
      if (outst_q == '0)
        err_d = 1'b1;
      else
        outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      weight_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      case (state_q)
        IDLE: begin
          weight_q <= cfg_weight_ch0_i;
          if (req_sel && !xfer)
            state_q <= sel ? HOLD1 : HOLD0;
        end
        HOLD0: begin
          if (xfer || !data_req_CH0_i)
            state_q <= IDLE;
        end
        HOLD1: begin
          if (xfer || !data_req_CH1_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outstanding_o   = outst_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_icache_bank_req_scheduler.sv
// Directed bench for icache_bank_req_scheduler: a vector table applied cycle by
// cycle, plus hand-written reset sequences.
module tb_icache_bank_req_scheduler;

  localparam logic [31:0] ADD0 = 32'hA000_1230;
  localparam logic [31:0] ADD1 = 32'h5000_4560;
  localparam logic [5:0]  ID0  = 6'h0A;
  localparam logic [5:0]  ID1  = 6'h35;

  logic        clk;
  logic        rst;
  logic        req0, req1, gnt0, gnt1;
  logic        req_o, gnt_i, rv_i;
  logic [31:0] add_o;
  logic [5:0]  id_o;
  logic [2:0]  cfg;
  logic [3:0]  outst;
  logic        err;

  int total  = 0;
  int passed = 0;

  icache_bank_req_scheduler #(
    .ADDR_MEM_WIDTH(32), .ID_WIDTH(6), .WEIGHT_WIDTH(3),
    .MAX_OUTSTANDING(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_CH0_i(req0), .data_add_CH0_i(ADD0), .data_ID_CH0_i(ID0), .data_gnt_CH0_o(gnt0),
    .data_req_CH1_i(req1), .data_add_CH1_i(ADD1), .data_ID_CH1_i(ID1), .data_gnt_CH1_o(gnt1),
    .data_req_o(req_o), .data_add_o(add_o), .data_ID_o(id_o),
    .data_gnt_i(gnt_i), .data_r_valid_i(rv_i),
    .cfg_weight_ch0_i(cfg), .outstanding_o(outst), .err_underflow_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0, r1, g, rv;
    logic [2:0] cfg;
    logic       e_req, e_g0, e_g1, e_sel;
    logic [3:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic r0, r1, g, rv, input logic [2:0] c,
                              input logic er, eg0, eg1, es, input logic [3:0] eo,
                              input logic ee);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.g = g; v.rv = rv; v.cfg = c;
    v.e_req = er; v.e_g0 = eg0; v.e_g1 = eg1; v.e_sel = es;
    v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r0, r1, g, rv, input logic [2:0] c);
    req0 = r0; req1 = r1; gnt_i = g; rv_i = rv; cfg = c;
  endtask

  initial begin
    // CH0 alone, three grants
    tbl[0]  = mk(1,0,1,0,2, 1,1,0,0, 1,0);
    tbl[1]  = mk(1,0,1,0,2, 1,1,0,0, 2,0);
    tbl[2]  = mk(1,0,1,0,2, 1,1,0,0, 3,0);
    tbl[3]  = mk(0,0,0,1,2, 0,0,0,0, 2,0);
    tbl[4]  = mk(0,0,0,1,2, 0,0,0,0, 1,0);
    // weight 2 round-robin with response every cycle
    tbl[5]  = mk(1,1,1,1,2, 1,1,0,0, 1,0);
    tbl[6]  = mk(1,1,1,1,2, 1,1,0,0, 1,0);
    tbl[7]  = mk(1,1,1,1,2, 1,0,1,1, 1,0);
    tbl[8]  = mk(1,1,1,1,2, 1,1,0,0, 1,0);
    tbl[9]  = mk(1,1,1,1,2, 1,1,0,0, 1,0);
    tbl[10] = mk(1,1,1,1,2, 1,0,1,1, 1,0);
    // CH1 stalled, held through CH0 request, then granted
    tbl[11] = mk(0,1,0,0,2, 1,0,0,1, 1,0);
    tbl[12] = mk(1,1,0,0,2, 1,0,0,1, 1,0);
    tbl[13] = mk(1,1,0,0,2, 1,0,0,1, 1,0);
    tbl[14] = mk(1,1,0,0,2, 1,0,0,1, 1,0);
    tbl[15] = mk(1,1,1,0,2, 1,0,1,1, 2,0);
    tbl[16] = mk(1,1,1,0,2, 1,1,0,0, 3,0);
    // credit limit
    tbl[17] = mk(1,0,1,0,2, 1,1,0,0, 4,0);
    tbl[18] = mk(1,0,1,0,2, 0,0,0,0, 4,0);
    tbl[19] = mk(1,0,1,1,2, 0,0,0,0, 3,0);
    tbl[20] = mk(1,0,1,0,2, 1,1,0,0, 4,0);
    tbl[21] = mk(0,0,0,1,2, 0,0,0,0, 3,0);
    tbl[22] = mk(1,0,1,1,2, 1,1,0,0, 3,0);
    tbl[23] = mk(0,0,0,1,2, 0,0,0,0, 2,0);
    tbl[24] = mk(0,0,0,1,2, 0,0,0,0, 1,0);
    tbl[25] = mk(0,0,0,1,2, 0,0,0,0, 0,0);
    // underflow, sticky
    tbl[26] = mk(0,0,0,1,2, 0,0,0,0, 0,1);
    tbl[27] = mk(0,0,0,0,0, 0,0,0,0, 0,1);
    // weight 0: CH1 wins every conflict
    tbl[28] = mk(1,1,1,0,0, 1,0,1,1, 1,1);
    tbl[29] = mk(1,1,1,1,0, 1,0,1,1, 1,1);

    rst = 1'b1;
    drive(1,1,1,0,2);
    #12;
    chk("reset req_o", req_o, 0);
    chk("reset gnt0", gnt0, 0);
    chk("reset gnt1", gnt1, 0);
    chk("reset outstanding", outst, 0);
    chk("reset err", err, 0);

    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0,2);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].r1, tbl[i].g, tbl[i].rv, tbl[i].cfg);
      #1;
      chk($sformatf("v%0d req_o", i), req_o, tbl[i].e_req);
      chk($sformatf("v%0d gnt0", i), gnt0, tbl[i].e_g0);
      chk($sformatf("v%0d gnt1", i), gnt1, tbl[i].e_g1);
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d ID", i), id_o, tbl[i].e_sel ? ID1 : ID0);
        chk($sformatf("v%0d addr", i), add_o, tbl[i].e_sel ? ADD1 : ADD0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d outstanding", i), outst, tbl[i].e_out);
      chk($sformatf("v%0d err", i), err, tbl[i].e_err);
    end

    // Underflow flag clears only on reset
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,0,7);
    #1;
    chk("rst clears err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1,1,1,0,7);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("w7 grant%0d ch0", k), gnt0, 1);
      @(negedge clk);
    end
    drive(1,1,0,0,7);
    chk("pre-hold outstanding", outst, 3);
    @(negedge clk);
    #1;
    chk("hold0 req_o", req_o, 1);
    chk("hold0 ID", id_o, ID0);

    // Asynchronous reset in the middle of HOLD0
    #2;
    rst = 1'b1;
    #1;
    chk("async rst req_o", req_o, 0);
    chk("async rst gnt0", gnt0, 0);
    chk("async rst gnt1", gnt1, 0);
    chk("async rst outstanding", outst, 0);

    @(negedge clk);
    rst = 1'b0;
    drive(0,1,0,0,1);
    #1;
    chk("post-rst idle req_o", req_o, 1);
    chk("post-rst idle ID", id_o, ID1);
    drive(0,0,0,0,1);
    @(posedge clk);
    @(negedge clk);
    drive(1,1,0,0,1);
    #1;
    chk("post-rst wcnt cleared ID", id_o, ID0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
